// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package adder_pkg;
    localparam int WORD_W = 8;

    typedef enum logic [1:0] {IDLE, ADD, HOLD} seq_state_t;
endpackage

// File: rtl/adder_sequencer_if.sv
// Operand/result valid-ready bus between source, sequencer and consumer.
interface adder_sequencer_if
    import adder_pkg::*;
#(
    parameter int W = 4 * WORD_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_8bit.sv
// One word of ripple-carry addition; 'overflow' is the unsigned carry out.
module adder_8bit
    import adder_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              carry_in,
    output logic [WORD_W-1:0] sum,
    output logic              overflow
);
    logic [WORD_W:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < WORD_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign overflow = c[WORD_W];
endmodule

// File: rtl/adder_sequencer.sv
// Adds two NUM_WORDS-word operands one word per cycle through a single
// 8-bit adder, chaining the carry through a register.
module adder_sequencer
    import adder_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input logic               clk,
    input logic               rst,
    adder_sequencer_if.slave  bus
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    seq_state_t state, state_nxt;

    logic [IDX_W-1:0]                   idx;
    logic [NUM_WORDS-1:0][WORD_W-1:0]   a_reg, b_reg, sum_reg;
    logic                               carry_reg, cout_reg, ovf_reg;
    logic [WORD_W-1:0]                  add_sum;
    logic                               add_cout;
    logic                               last;

    assign last = (idx == IDX_W'(NUM_WORDS - 1));

    adder_8bit u_adder (
        .a        (a_reg[idx]),
        .b        (b_reg[idx]),
        .carry_in (carry_reg),
        .sum      (add_sum),
        .overflow (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = ADD;
            ADD:     if (last)          state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.sum       = sum_reg;
    assign bus.carry_out = cout_reg;
    assign bus.overflow  = ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_reg     <= bus.a;
                    b_reg     <= bus.b;
                    carry_reg <= bus.carry_in;
                    idx       <= '0;
                end
                ADD: begin
                    sum_reg[idx] <= add_sum;
                    carry_reg    <= add_cout;
                    if (last) begin
                        cout_reg <= add_cout;
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_reg  <= (a_reg[idx][WORD_W-1] == b_reg[idx][WORD_W-1]) &&
                                    (add_sum[WORD_W-1] != a_reg[idx][WORD_W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_sequencer.sv
// Randomized and directed checks of adder_sequencer against a plain-arithmetic model.
module tb_adder_sequencer;
    localparam int NW = 4;
    localparam int W  = NW * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    adder_sequencer_if #(.W(W)) bus ();

    adder_sequencer #(.NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic cin,
                          input int hold_n, input bit junk, output logic [W-1:0] got_sum);
        logic [W:0]   full;
        logic [W-1:0] e_sum;
        logic         e_cout, e_ovf;
        int           lat;
        full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin};
        e_sum  = full[W-1:0];
        e_cout = full[W];
        e_ovf  = (a_i[W-1] == b_i[W-1]) && (e_sum[W-1] != a_i[W-1]);
        got_sum = '0;

        chk("ready_idle", bus.in_ready, 1'b1);
        bus.a = a_i; bus.b = b_i; bus.carry_in = cin; bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (junk) begin
                bus.in_valid = $urandom_range(0, 1);
                bus.a = $urandom; bus.b = $urandom; bus.carry_in = $urandom_range(0, 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (!bus.out_valid) chk("ready_busy", bus.in_ready, 1'b0);
        end while (!bus.out_valid && lat < 20);
        bus.in_valid = 1'b0;
        if (!bus.out_valid) begin
            chk("timeout", 1'b0, 1'b1);
            return;
        end
        // Cycles counted from the accept cycle to the first out_valid cycle.
        chk("latency", lat, NW + 1);
        chk("sum", bus.sum, e_sum);
        chk("cout", bus.carry_out, e_cout);
        chk("ovf", bus.overflow, e_ovf);
        got_sum = bus.sum;
        for (int i = 0; i < hold_n; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_ready", bus.in_ready, 1'b0);
            chk("hold_sum", {bus.carry_out, bus.overflow, bus.sum}, {e_cout, e_ovf, e_sum});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("drop_valid", bus.out_valid, 1'b0);
        chk("kept_sum", bus.sum, e_sum);
    endtask

    initial begin
        logic [W-1:0] s;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", {bus.out_valid, bus.in_ready, bus.carry_out, bus.overflow}, 4'b0100);
        chk("rst_sum", bus.sum, '0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, s);
        chk("t2_sum", s, 32'h0000_0000);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, s);
        chk("t3_sum", s, 32'h8000_0000);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 1'b0, s);
        chk("t4_sum", s, 32'h2345_678A);
        run_op(32'hDEAD_BEEF, 32'h8000_0001, 1'b1, 5, 1'b1, s);

        // Reset during the second ADD cycle discards the operation.
        bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.carry_in = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", {bus.out_valid, bus.in_ready}, 2'b01);
        chk("midrst_sum", bus.sum, '0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 1'b0, s);
        chk("t6_sum", s, 32'h2345_678A);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (n % 5 == 0) rb = ~ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
